// File: rtl/immenc_pkg.sv
// ---------------------------------------------------------------------------
// immenc_pkg : immediate-format encodings, error bit indices, field widths
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package immenc_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  localparam int XLEN      = 32;
  localparam int ENC_LSB   = 7;
  localparam int ENC_W     = 25;
  localparam int ERR_W     = 2;
  localparam int ERR_RANGE = 0;
  localparam int ERR_ALIGN = 1;
  localparam int CNT_W     = 8;

  // True when v[XLEN-1:msb] are all copies of one bit, i.e. v is a sign
  // extension of its low msb+1 bits.
  function automatic logic sext_fits(input logic [XLEN-1:0] v, input int unsigned msb);
    logic [XLEN-1:0] sh;
    sh = XLEN'($signed(v) >>> msb);
    return (sh == '0) || (sh == '1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/immenc_core.sv
// ---------------------------------------------------------------------------
// immenc_core : combinational immediate scatter into instruction bits [31:7]
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module immenc_core
  import immenc_pkg::*;
(
  input  logic [1:0]       immsrc,
  input  logic [XLEN-1:0]  imm,
  output logic [ENC_W-1:0] enc,
  output logic [ENC_W-1:0] mask,
  output logic [ERR_W-1:0] err
);

  logic [31:ENC_LSB] enc_raw;
  logic [31:ENC_LSB] mask_raw;

  always_comb begin
    enc_raw  = '0;
    mask_raw = '0;
    err      = '0;
    case (immsrc_e'(immsrc))
      IMM_I: begin
        enc_raw[31:20]  = imm[11:0];
        mask_raw[31:20] = '1;
        err[ERR_RANGE]  = !sext_fits(imm, 11);
      end
      IMM_S: begin
        enc_raw[31:25]  = imm[11:5];
        enc_raw[11:7]   = imm[4:0];
        mask_raw[31:25] = '1;
        mask_raw[11:7]  = '1;
        err[ERR_RANGE]  = !sext_fits(imm, 11);
      end
      IMM_B: begin
        enc_raw[31]     = imm[12];
        enc_raw[30:25]  = imm[10:5];
        enc_raw[11:8]   = imm[4:1];
        enc_raw[7]      = imm[11];
        mask_raw[31:25] = '1;
        mask_raw[11:7]  = '1;
        err[ERR_RANGE]  = !sext_fits(imm, 12);
        err[ERR_ALIGN]  = imm[0];
      end
      IMM_J: begin
        enc_raw[31]     = imm[20];
        enc_raw[30:21]  = imm[10:1];
        enc_raw[20]     = imm[11];
        enc_raw[19:12]  = imm[19:12];
        mask_raw[31:12] = '1;
        err[ERR_RANGE]  = !sext_fits(imm, 20);
        err[ERR_ALIGN]  = imm[0];
      end
      default: begin
        enc_raw  = '0;
        mask_raw = '0;
      end
    endcase
    // An unencodable value must never leak partial fields downstream.
    enc  = (err == '0) ? enc_raw : '0;
    mask = mask_raw;
  end

endmodule

`default_nettype wire

// File: rtl/immenc.sv
// ---------------------------------------------------------------------------
// immenc : two-stage valid/ready pipeline around immenc_core
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module immenc
  import immenc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       immsrc,
  input  logic [XLEN-1:0]  imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ENC_W-1:0] enc,
  output logic [ENC_W-1:0] mask,
  output logic [ERR_W-1:0] err,
  output logic [CNT_W-1:0] err_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_immsrc_q, s1_immsrc_d;
  logic [XLEN-1:0]  s1_imm_q, s1_imm_d;
  logic             out_valid_q, out_valid_d;
  logic [ENC_W-1:0] enc_q, enc_d;
  logic [ENC_W-1:0] mask_q, mask_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [ENC_W-1:0] core_enc;
  logic [ENC_W-1:0] core_mask;
  logic [ERR_W-1:0] core_err;

  logic s2_load;
  logic in_fire;
  logic out_fire;

  immenc_core u_core (
    .immsrc (s1_immsrc_q),
    .imm    (s1_imm_q),
    .enc    (core_enc),
    .mask   (core_mask),
    .err    (core_err)
  );

  // Handshakes are masked during reset so nothing transfers in that cycle.
  assign s2_load   = !out_valid_q || out_ready;
  assign in_ready  = !reset && (!s1_valid_q || s2_load);
  assign out_valid = out_valid_q && !reset;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign enc       = enc_q;
  assign mask      = mask_q;
  assign err       = err_q;
  assign err_count = err_count_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_immsrc_d = s1_immsrc_q;
    s1_imm_d    = s1_imm_q;
    out_valid_d = out_valid_q;
    enc_d       = enc_q;
    mask_d      = mask_q;
    err_d       = err_q;
    err_count_d = err_count_q;

    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        enc_d  = core_enc;
        mask_d = core_mask;
        err_d  = core_err;
      end
      s1_valid_d = 1'b0;
    end

    if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_immsrc_d = immsrc;
      s1_imm_d    = imm;
    end

    if (out_fire && (err_q != '0) && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_immsrc_q <= '0;
      s1_imm_q    <= '0;
      out_valid_q <= 1'b0;
      enc_q       <= '0;
      mask_q      <= '0;
      err_q       <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_immsrc_q <= s1_immsrc_d;
      s1_imm_q    <= s1_imm_d;
      out_valid_q <= out_valid_d;
      enc_q       <= enc_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_immenc.sv
// ---------------------------------------------------------------------------
// tb_immenc : directed and random stimulus against a reference encoder model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_immenc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  immsrc;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] enc;
  logic [24:0] mask;
  logic [1:0]  err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  immenc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .immsrc    (immsrc),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .enc       (enc),
    .mask      (mask),
    .err       (err),
    .err_count (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
  } req_t;

  req_t q[$];
  int   model_cnt = 0;
  int   pops = 0;

  // Reference encoder: range from signed value limits, fields placed per format.
  function automatic void model(input logic [1:0] s, input logic [31:0] v,
                                output logic [24:0] e, output logic [24:0] m,
                                output logic [1:0] er);
    int signed   x;
    logic [31:0] e32;
    logic [31:0] m32;
    x   = $signed(v);
    e32 = '0;
    m32 = '0;
    er  = '0;
    case (s)
      2'd0: begin
        if (x < -2048 || x > 2047) er[0] = 1'b1;
        e32[31:20] = v[11:0];
        m32 = 32'hFFF0_0000;
      end
      2'd1: begin
        if (x < -2048 || x > 2047) er[0] = 1'b1;
        e32[31:25] = v[11:5];
        e32[11:7]  = v[4:0];
        m32 = 32'hFE00_0F80;
      end
      2'd2: begin
        if (x < -4096 || x > 4095) er[0] = 1'b1;
        er[1] = v[0];
        e32[31]    = v[12];
        e32[30:25] = v[10:5];
        e32[11:8]  = v[4:1];
        e32[7]     = v[11];
        m32 = 32'hFE00_0F80;
      end
      default: begin
        if (x < -(1 << 20) || x > (1 << 20) - 1) er[0] = 1'b1;
        er[1] = v[0];
        e32[31]    = v[20];
        e32[30:21] = v[10:1];
        e32[20]    = v[11];
        e32[19:12] = v[19:12];
        m32 = 32'hFFFF_F000;
      end
    endcase
    if (er != 2'b00) e32 = '0;
    e = e32[31:7];
    m = m32[31:7];
  endfunction

  function automatic logic [31:0] decode(input logic [1:0] s, input logic [24:0] e25);
    logic [31:0] e;
    e = {e25, 7'b0};
    case (s)
      2'd0:    decode = {{20{e[31]}}, e[31:20]};
      2'd1:    decode = {{20{e[31]}}, e[31:25], e[11:7]};
      2'd2:    decode = {{19{e[31]}}, e[31], e[7], e[30:25], e[11:8], 1'b0};
      default: decode = {{11{e[31]}}, e[31], e[19:12], e[20], e[30:21], 1'b0};
    endcase
  endfunction

  // Per-cycle compare against the queue model.
  logic        prev_stall = 1'b0;
  logic [24:0] p_enc, p_mask;
  logic [1:0]  p_err;

  always @(negedge clk) begin
    logic [24:0] ee, em;
    logic [1:0]  er;
    req_t        r;
    if (reset) begin
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      chk("err_count", {24'b0, err_count}, model_cnt);
      chk("in_ready", {31'b0, in_ready}, {31'b0, !(q.size() == 2 && !out_ready)});
      if (prev_stall) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_enc", {7'b0, enc}, {7'b0, p_enc});
        chk("hold_mask", {7'b0, mask}, {7'b0, p_mask});
        chk("hold_err", {30'b0, err}, {30'b0, p_err});
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got output enc=%h with no request in flight", enc);
        end else begin
          r = q.pop_front();
          pops++;
          model(r.src, r.imm, ee, em, er);
          chk("enc", {7'b0, enc}, {7'b0, ee});
          chk("mask", {7'b0, mask}, {7'b0, em});
          chk("err", {30'b0, err}, {30'b0, er});
          if (er == 2'b00) chk("roundtrip", decode(r.src, enc), r.imm);
          if (er != 2'b00 && model_cnt < 255) model_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      p_enc  = enc;
      p_mask = mask;
      p_err  = err;
      if (in_valid && in_ready) begin
        r.src = immsrc;
        r.imm = imm;
        q.push_back(r);
      end
    end
  end

  // Presents one request and returns at the negedge where it is accepted.
  task automatic send(input logic [1:0] s, input logic [31:0] v);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    immsrc   = s;
    imm      = v;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input logic [1:0] s, input logic [31:0] v,
                        input logic [24:0] xe, input logic [24:0] xm, input logic [1:0] xr);
    int lat;
    logic seen;
    out_ready = 1'b1;
    send(s, v);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    chk("latency", lat, 32'd2);
    chk("lit_enc", {7'b0, enc}, {7'b0, xe});
    chk("lit_mask", {7'b0, mask}, {7'b0, xm});
    chk("lit_err", {30'b0, err}, {30'b0, xr});
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 32'd0);
  endtask

  logic [1:0]  s8[8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3};
  logic [31:0] v8[8] = '{32'h0000_0123, 32'hFFFF_F800, 32'h0000_0FFE, 32'h000F_FFFE,
                         32'hFFFF_FFFF, 32'hFFFF_F000, 32'h0000_0800, 32'h0000_0001};
  logic        pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int idx, cyc, cnt, p0;
    logic acc;
    reset = 1'b1; in_valid = 1'b0; immsrc = '0; imm = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_enc", {7'b0, enc}, 32'd0);
    chk("rst_mask", {7'b0, mask}, 32'd0);
    chk("rst_err", {30'b0, err}, 32'd0);
    chk("rst_cnt", {24'b0, err_count}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    single(2'd0, 32'hFFFF_F800, 25'h100_0000, 25'h1FF_E000, 2'b00);
    single(2'd1, 32'h0000_07FF, 25'h0FC_001F, 25'h1FC_001F, 2'b00);
    single(2'd2, 32'h0000_0FFE, 25'h0FC_001F, 25'h1FC_001F, 2'b00);
    single(2'd3, 32'hFFFF_FFFE, 25'h1FF_FFE0, 25'h1FF_FFE0, 2'b00);
    single(2'd3, 32'h0010_0000, 25'h000_0000, 25'h1FF_FFE0, 2'b01);
    @(negedge clk);
    chk("lit_cnt_1", {24'b0, err_count}, 32'd1);
    single(2'd2, 32'h0000_0003, 25'h000_0000, 25'h1FC_001F, 2'b10);
    single(2'd1, 32'hFFFF_F7FF, 25'h000_0000, 25'h1FC_001F, 2'b01);

    // 300 back-to-back errors saturate the counter.
    @(posedge clk); #1;
    in_valid = 1'b1; immsrc = 2'd3; imm = 32'h0010_0000; out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2000 && cnt < 300; i++) begin
      @(negedge clk);
      if (in_ready) cnt++;
      if (cnt < 300) @(posedge clk);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    chk("lit_cnt_sat", {24'b0, err_count}, 32'd255);

    // Stream of 8 with out_ready toggled 1,0,0,1.
    p0 = pops; idx = 0; cyc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; immsrc = s8[0]; imm = v8[0]; out_ready = pat[0];
    while (idx < 8 && cyc < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (idx < 8) begin immsrc = s8[idx]; imm = v8[idx]; end
      else in_valid = 1'b0;
      out_ready = pat[cyc % 4];
    end
    drain();
    chk("stream_count", pops - p0, 32'd8);

    // Random legal values with random back-pressure.
    idx = 0; cyc = 0;
    while (idx < 40 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid || acc) begin
        immsrc = 2'($urandom_range(0, 3));
        case (immsrc)
          2'd0, 2'd1: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
          2'd2:       imm = 32'(int'($urandom_range(0, 4095)) * 2 - 4096);
          default:    imm = 32'(int'($urandom_range(0, (1 << 20) - 1)) * 2 - (1 << 20));
        endcase
      end
      in_valid = 1'b1;
      @(negedge clk); acc = in_ready;
      if (acc) idx++;
    end
    @(posedge clk); #1; in_valid = 1'b0;
    drain();

    // Reset with two requests in flight.
    out_ready = 1'b0;
    send(2'd0, 32'h0000_0055);
    send(2'd1, 32'h0000_0066);
    @(posedge clk); #1; in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1; reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("after_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("after_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("after_rst_cnt", {24'b0, err_count}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_out", {31'b0, out_valid}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
